// File: rtl/gate_ctrl_pkg.sv
// Shared types and defaults for the clock-gate enable controller.
// The enum encoding is fixed so that the state can be observed by index.
package gate_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAKE   = 2'd1,
      ACTIVE = 2'd2,
      HOLD   = 2'd3
   } gate_state_t;

   localparam int unsigned DEF_WIDTH       = 8;
   localparam int unsigned DEF_WAKE_CYCLES = 1;
   localparam int unsigned DEF_HOLD_CYCLES = 4;
   localparam int unsigned DEF_CNT_W       = 16;

   // The counters load cycles-1, so they need enough bits for max(a,b)-1.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/gate_ctrl_down_counter.sv
// Loadable down-counter with a zero flag; stops at zero.
module gate_ctrl_down_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic [W-1:0] count_o,
   output logic         zero_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign zero_o  = (count_q == '0);

endmodule

// File: rtl/gate_enable_ctrl.sv
// Enable-side controller for a clock-gated arithmetic unit: wakes the domain,
// issues operand sets, suppresses repeats and gates off after a hold window.
//
//   state  | meaning
//   IDLE   | domain gated off, waiting for in_valid
//   WAKE   | enable asserted, letting the gated clock settle
//   ACTIVE | accepting operand sets
//   HOLD   | no traffic, counting down before gating off
module gate_enable_ctrl
   import gate_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH       = DEF_WIDTH,
   parameter int unsigned WAKE_CYCLES = DEF_WAKE_CYCLES,
   parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int unsigned CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             cg_enable,
   output logic             op_valid,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic             op_cin,
   output logic             dup_hit,
   output logic [CNT_W-1:0] off_cycles
);

   localparam int unsigned CW = cnt_width(WAKE_CYCLES, HOLD_CYCLES);

   gate_state_t      state_q, state_d;
   logic             cg_enable_q, cg_enable_d;
   logic             op_valid_q, op_valid_d;
   logic             dup_hit_q, dup_hit_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic             op_cin_q, op_cin_d;
   logic             last_vld_q, last_vld_d;
   logic [CNT_W-1:0] off_q, off_d;

   logic          wake_load, wake_dec, wake_zero;
   logic          hold_load, hold_dec, hold_zero;
   logic [CW-1:0] wake_cnt, hold_cnt;
   logic          last_clr;
   logic          accept;
   logic          is_dup;

   gate_ctrl_down_counter #(.W(CW)) u_wake (
      .clk        (clk),
      .rst        (rst),
      .load_i     (wake_load),
      .load_val_i (CW'(WAKE_CYCLES - 1)),
      .dec_i      (wake_dec),
      .count_o    (wake_cnt),
      .zero_o     (wake_zero)
   );

   gate_ctrl_down_counter #(.W(CW)) u_hold (
      .clk        (clk),
      .rst        (rst),
      .load_i     (hold_load),
      .load_val_i (CW'(HOLD_CYCLES - 1)),
      .dec_i      (hold_dec),
      .count_o    (hold_cnt),
      .zero_o     (hold_zero)
   );

   assign in_ready = (state_q == ACTIVE) || (state_q == HOLD);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d   = state_q;
      wake_load = 1'b0;
      wake_dec  = 1'b0;
      hold_load = 1'b0;
      hold_dec  = 1'b0;
      last_clr  = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d   = WAKE;
               wake_load = 1'b1;
            end
         end
         WAKE: begin
            if (wake_zero) begin
               state_d = ACTIVE;
            end else begin
               wake_dec = 1'b1;
            end
         end
         ACTIVE: begin
            if (!in_valid) begin
               state_d   = HOLD;
               hold_load = 1'b1;
            end
         end
         HOLD: begin
            // an accept on the last hold cycle keeps the domain awake
            if (accept) begin
               state_d = ACTIVE;
            end else if (hold_zero) begin
               state_d  = IDLE;
               last_clr = 1'b1;
            end else begin
               hold_dec = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // op_* only ever change on an issued set, so they double as the last-issued record
   assign is_dup = last_vld_q && (in_a == op_a_q) && (in_b == op_b_q) && (in_cin == op_cin_q);

   always_comb begin
      cg_enable_d = (state_d != IDLE);
      op_valid_d  = accept && !is_dup;
      dup_hit_d   = accept && is_dup;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      op_cin_d    = op_cin_q;
      last_vld_d  = last_vld_q;
      if (op_valid_d) begin
         op_a_d     = in_a;
         op_b_d     = in_b;
         op_cin_d   = in_cin;
         last_vld_d = 1'b1;
      end
      if (last_clr) begin
         last_vld_d = 1'b0;
      end
      off_d = off_q;
      if (!cg_enable_q && (off_q != '1)) begin
         off_d = off_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cg_enable_q <= 1'b0;
         op_valid_q  <= 1'b0;
         dup_hit_q   <= 1'b0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_cin_q    <= 1'b0;
         last_vld_q  <= 1'b0;
         off_q       <= '0;
      end else begin
         state_q     <= state_d;
         cg_enable_q <= cg_enable_d;
         op_valid_q  <= op_valid_d;
         dup_hit_q   <= dup_hit_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         op_cin_q    <= op_cin_d;
         last_vld_q  <= last_vld_d;
         off_q       <= off_d;
      end
   end

   assign cg_enable  = cg_enable_q;
   assign op_valid   = op_valid_q;
   assign dup_hit    = dup_hit_q;
   assign op_a       = op_a_q;
   assign op_b       = op_b_q;
   assign op_cin     = op_cin_q;
   assign off_cycles = off_q;

endmodule

// File: tb/tb_gate_enable_ctrl.sv
// Directed bench for gate_enable_ctrl; a second narrow-counter instance covers saturation.
`timescale 1ns/1ps
module tb_gate_enable_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a, in_b;
   logic       in_cin;
   logic       cg_enable, op_valid, op_cin, dup_hit;
   logic [7:0] op_a, op_b;
   logic [15:0] off_cycles;

   logic       s_valid;
   logic       s_ready, s_cg, s_opv, s_cin, s_dup;
   logic [7:0] s_in_a, s_in_b, s_a, s_b;
   logic       s_in_cin;
   logic [3:0] s_off;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   gate_enable_ctrl #(.WIDTH(8), .WAKE_CYCLES(1), .HOLD_CYCLES(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .cg_enable(cg_enable),
      .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
      .dup_hit(dup_hit), .off_cycles(off_cycles)
   );

   gate_enable_ctrl #(.WIDTH(8), .WAKE_CYCLES(1), .HOLD_CYCLES(4), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_ready),
      .in_a(s_in_a), .in_b(s_in_b), .in_cin(s_in_cin), .cg_enable(s_cg),
      .op_valid(s_opv), .op_a(s_a), .op_b(s_b), .op_cin(s_cin),
      .dup_hit(s_dup), .off_cycles(s_off)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
      in_valid = v;
      in_a     = a;
      in_b     = b;
      in_cin   = c;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 20; i++) begin
         if (!cg_enable) break;
         tick();
      end
      chk(tag, cg_enable, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      s_valid = 1'b0; s_in_a = 8'h00; s_in_b = 8'h00; s_in_cin = 1'b0;
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      repeat (2) tick();
      chk("rst_cg",    cg_enable, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_opv",   op_valid, 0);
      chk("rst_dup",   dup_hit, 0);
      chk("rst_opa",   op_a, 0);
      chk("rst_off",   off_cycles, 0);
      rst = 1'b1;

      // idle, then narrow counter saturation
      repeat (10) tick();
      chk("idle_off",   off_cycles, 10);
      chk("idle_cg",    cg_enable, 0);
      chk("idle_ready", in_ready, 0);
      chk("sat_10",     s_off, 10);
      repeat (4) tick();
      chk("sat_14", s_off, 14);
      tick();
      chk("sat_15", s_off, 15);
      repeat (5) tick();
      chk("sat_hold", s_off, 15);
      chk("off_20",   off_cycles, 20);

      // cold start
      drive(1'b1, 8'h3C, 8'h05, 1'b1);
      tick();
      chk("cold_cg_t1",    cg_enable, 1);
      chk("cold_ready_t1", in_ready, 0);
      tick();
      chk("cold_ready_t2", in_ready, 1);
      tick();
      chk("cold_opv_t3",  op_valid, 1);
      chk("cold_opa_t3",  op_a, 8'h3C);
      chk("cold_opb_t3",  op_b, 8'h05);
      chk("cold_cin_t3",  op_cin, 1);
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      chk("cold_opv_t4", op_valid, 0);
      repeat (3) tick();
      chk("cold_cg_t7",    cg_enable, 1);
      chk("cold_state_t7", dut.state_q, 2'd3);
      tick();
      chk("cold_cg_t8",    cg_enable, 0);
      chk("cold_state_t8", dut.state_q, 2'd0);
      chk("cold_off_t8",   off_cycles, 21);

      // back-to-back
      drive(1'b1, 8'h01, 8'h02, 1'b0);
      repeat (3) tick();
      chk("b2b_v0",  op_valid, 1);
      chk("b2b_a0",  op_a, 8'h01);
      chk("b2b_b0",  op_b, 8'h02);
      drive(1'b1, 8'h10, 8'h20, 1'b0);
      tick();
      chk("b2b_v1",  op_valid, 1);
      chk("b2b_a1",  op_a, 8'h10);
      chk("b2b_b1",  op_b, 8'h20);
      drive(1'b1, 8'hFF, 8'hFF, 1'b0);
      tick();
      chk("b2b_v2",  op_valid, 1);
      chk("b2b_a2",  op_a, 8'hFF);
      chk("b2b_b2",  op_b, 8'hFF);
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      chk("b2b_end", op_valid, 0);
      wait_idle("b2b_idle");

      // duplicate suppression
      drive(1'b1, 8'hAA, 8'h55, 1'b0);
      repeat (3) tick();
      chk("dup_first_v", op_valid, 1);
      chk("dup_first_d", dup_hit, 0);
      chk("dup_first_a", op_a, 8'hAA);
      tick();
      chk("dup_second_v", op_valid, 0);
      chk("dup_second_d", dup_hit, 1);
      chk("dup_second_a", op_a, 8'hAA);
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      chk("dup_pulse_end", dup_hit, 0);
      wait_idle("dup_idle");
      drive(1'b1, 8'hAA, 8'h55, 1'b0);
      repeat (3) tick();
      chk("dup_reissue_v", op_valid, 1);
      chk("dup_reissue_d", dup_hit, 0);
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      wait_idle("dup2_idle");

      // accept on the last hold cycle
      drive(1'b1, 8'h11, 8'h22, 1'b0);
      repeat (3) tick();
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("hz_cg_hold", cg_enable, 1);
      end
      chk("hz_state", dut.state_q, 2'd3);
      chk("hz_cnt",   dut.hold_cnt, 0);
      drive(1'b1, 8'h33, 8'h44, 1'b0);
      tick();
      chk("hz_opv",   op_valid, 1);
      chk("hz_opa",   op_a, 8'h33);
      chk("hz_st_act", dut.state_q, 2'd2);
      chk("hz_cg",    cg_enable, 1);
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      wait_idle("hz_idle");

      // reset in the middle of a burst
      drive(1'b1, 8'h5A, 8'hA5, 1'b1);
      repeat (3) tick();
      chk("mr_opv_pre", op_valid, 1);
      drive(1'b1, 8'h66, 8'h77, 1'b0);
      rst = 1'b0;
      #1;
      chk("mr_cg",    cg_enable, 0);
      chk("mr_ready", in_ready, 0);
      chk("mr_opv",   op_valid, 0);
      chk("mr_dup",   dup_hit, 0);
      chk("mr_opa",   op_a, 0);
      chk("mr_opb",   op_b, 0);
      chk("mr_cin",   op_cin, 0);
      chk("mr_off",   off_cycles, 0);
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      chk("mr_after_ready", in_ready, 0);
      chk("mr_after_off",   off_cycles, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/gate_enable_ctrl.md
# gate_enable_ctrl

Enable-side controller for the clock-gated arithmetic units (gated RCA, approximate multiplier partial-product adders). It accepts operand transactions from upstream through a valid/ready handshake and drives the `enable` input of a clock gating cell. It wakes the gated domain before issuing operands and keeps it on for a hold window after the last operand, then turns it off. It also suppresses duplicate operand sets and counts gated-off cycles for power accounting.

## Interface
- `WIDTH`, 8: operand width, must be ≥1.
- `WAKE_CYCLES`, 1: cycles spent in WAKE before operands are accepted, must be ≥1.
- `HOLD_CYCLES`, 4: idle cycles tolerated in HOLD before gating off, must be ≥1.
- `CNT_W`, 16: width of the gated-off cycle counter.
- `clk`  in  1  free-running clock, ungated.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream operand set valid.
- `in_ready`  out  1  controller accepts this cycle.
- `in_a`, `in_b`  in  WIDTH  operands.
- `in_cin`  in  1  carry-in.
- `cg_enable`  out  1  registered; drives the gating cell `enable`.
- `op_valid`  out  1  one-cycle pulse: new operands on `op_*`.
- `op_a`, `op_b`  out  WIDTH  registered operands to the gated datapath.
- `op_cin`  out  1  registered carry-in.
- `dup_hit`  out  1  one-cycle pulse: accepted set equals last issued set, not issued.
- `off_cycles`  out  CNT_W  saturating count of cycles with `cg_enable`=0.

## Operation
- The FSM has four states: IDLE, WAKE, ACTIVE and HOLD. The state register resets to IDLE.
- `in_ready` is 1 in ACTIVE and HOLD and 0 in IDLE and WAKE. Accept occurs when `in_valid` & `in_ready`.
- IDLE:
  - `in_valid`=1 → WAKE, and the wake counter loads WAKE_CYCLES-1.
  - Otherwise the FSM stays in IDLE.
- WAKE:
  - Counter at 0 → ACTIVE.
  - Otherwise the counter decrements. `in_valid` is ignored, and upstream must hold it.
- ACTIVE:
  - Accept → stay in ACTIVE.
  - `in_valid`=0 → HOLD, and the hold counter loads HOLD_CYCLES-1.
- HOLD:
  - Accept → ACTIVE.
  - Otherwise, counter at 0 → IDLE.
  - Otherwise the counter decrements.
- `cg_enable` is registered and equals 1 when the next state is WAKE, ACTIVE or HOLD.
- Accept of a non-duplicate set:
  - The next cycle registers `op_a`/`op_b`/`op_cin`, pulses `op_valid`, sets `last_vld` and stores the set as the last issued.
- Duplicate set:
  - Condition: `last_vld`=1 and {`in_a`,`in_b`,`in_cin`} equals the last issued set.
  - The next cycle pulses `dup_hit`. `op_valid` stays 0 and `op_*` are unchanged.
- `last_vld` clears on reset and on the transition HOLD→IDLE.
- `off_cycles` increments in every cycle where the registered `cg_enable`=0, and saturates at all-ones (no wrap).
- `op_*` hold their value across IDLE.

## Timing
- Reset values: `cg_enable`=0, `in_ready`=0, `op_valid`=0, `dup_hit`=0, `op_a`=`op_b`=0, `op_cin`=0, `off_cycles`=0, counters=0, `last_vld`=0.
- Reset is asynchronous, so assertion mid-operation clears all state immediately, including an `op_valid` pulse in flight.
- Cold-start latency, with `in_valid` rising at cycle t in IDLE:
  - `cg_enable`=1 from t+1.
  - ACTIVE and `in_ready`=1 at t+1+WAKE_CYCLES.
  - `op_valid` one cycle after accept.
- Warm latency: accept to `op_valid` is 1 cycle.
- Throughput: one accept per cycle in ACTIVE and HOLD.
- Gate-off delay: after the last accept, `cg_enable` stays 1 for HOLD_CYCLES+1 cycles, then falls. The last `op_valid` therefore always occurs with `cg_enable`=1.
- Simultaneous events:
  - Accept in HOLD on the cycle the counter reaches 0: accept wins, and the next state is ACTIVE.
  - A duplicate accept in HOLD still returns to ACTIVE and restarts the hold window on the next idle cycle.
- `in_valid` dropping during WAKE is legal: after WAKE the FSM enters ACTIVE, then HOLD, then IDLE with no accept.

## Structure
- Package `gate_ctrl_pkg` contains:
  - the `gate_state_t` enum: IDLE=2'd0, WAKE=2'd1, ACTIVE=2'd2, HOLD=2'd3;
  - shared localparams for the default WAKE/HOLD values.
- Sub-module `gate_ctrl_down_counter` is a loadable down-counter with a zero flag. It is instantiated twice, once for wake and once for hold; a single shared instance is acceptable.
- The duplicate compare and the `off_cycles` saturation stay in the top module.

## Test plan
All scenarios use WIDTH=8, WAKE_CYCLES=1 and HOLD_CYCLES=4.
- Reset then idle 10 cycles → `cg_enable`=0, `in_ready`=0, `off_cycles`=10.
- Cold start: `in_valid` with a=0x3C, b=0x05, cin=1 at t → `cg_enable`=1 at t+1, accept at t+2, `op_valid` with `op_a`=0x3C at t+3, `cg_enable` falls at t+8, FSM back in IDLE.
- Back-to-back sets 0x01/0x02, 0x10/0x20, 0xFF/0xFF in ACTIVE → three consecutive `op_valid` pulses carrying those values, no gaps.
- Same set 0xAA/0x55/0 twice consecutively → one `op_valid` followed by one `dup_hit`, `op_a` stays 0xAA. After gating off, the same set produces `op_valid` again.
- Accept in the HOLD cycle where the counter is 0 → state ACTIVE, `cg_enable` never drops.
- Force `off_cycles` near all-ones, then idle past saturation → holds 0xFFFF. Assert `rst`=0 mid-burst → all outputs are at reset values in the same cycle.
